pe_stream_controller: RTL and testbench

PE_STREAM_CONTROLLER -- requirements
Module: pe_stream_controller

---
 rtl/pe_stream_controller.sv | 205 ++++++++++++++++++++
 tb/tb_pe_stream_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_stream_controller.sv
// Layer controller for a single PE. It latches a layer shape, configures the PE for one cycle,
// streams ifmap/filter/ipsum words into the PE and opsum words out until every quota is met.
module pe_stream_controller #(
  parameter int DATA_WIDTH_IFMAP  = 16,
  parameter int DATA_WIDTH_FILTER = 64,
  parameter int DATA_WIDTH_PSUM   = 64,
  parameter int S_WIDTH           = 5,
  parameter int F_WIDTH           = 6,
  parameter int U_WIDTH           = 3,
  parameter int n_WIDTH           = 3,
  parameter int p_WIDTH           = 5,
  parameter int q_WIDTH           = 3,
  parameter int W_WIDTH           = 8,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [S_WIDTH-1:0]           cfg_S,
  input  logic [F_WIDTH-1:0]           cfg_F,
  input  logic [U_WIDTH-1:0]           cfg_U,
  input  logic [n_WIDTH-1:0]           cfg_n,
  input  logic [p_WIDTH-1:0]           cfg_p,
  input  logic [q_WIDTH-1:0]           cfg_q,
  input  logic [W_WIDTH-1:0]           cfg_W,
  output logic                         busy,
  output logic                         done,
  output logic                         pe_enable,
  output logic                         pe_configure,
  output logic [S_WIDTH-1:0]           pe_S,
  output logic [F_WIDTH-1:0]           pe_F,
  output logic [U_WIDTH-1:0]           pe_U,
  output logic [n_WIDTH-1:0]           pe_n,
  output logic [p_WIDTH-1:0]           pe_p,
  output logic [q_WIDTH-1:0]           pe_q,
  output logic                         push_ifmap,
  output logic [DATA_WIDTH_IFMAP-1:0]  ifmap,
  input  logic                         ifmap_fifo_full,
  output logic                         push_filter,
  output logic [DATA_WIDTH_FILTER-1:0] filter,
  input  logic                         filter_fifo_full,
  output logic                         push_ipsum,
  output logic [DATA_WIDTH_PSUM-1:0]   ipsum,
  input  logic                         ipsum_fifo_full,
  output logic                         pop_opsum,
  input  logic [DATA_WIDTH_PSUM-1:0]   opsum,
  input  logic                         opsum_fifo_empty,
  input  logic                         ifmap_src_valid,
  input  logic [DATA_WIDTH_IFMAP-1:0]  ifmap_src_data,
  output logic                         ifmap_src_ready,
  input  logic                         filter_src_valid,
  input  logic [DATA_WIDTH_FILTER-1:0] filter_src_data,
  output logic                         filter_src_ready,
  input  logic                         ipsum_src_valid,
  input  logic [DATA_WIDTH_PSUM-1:0]   ipsum_src_data,
  output logic                         ipsum_src_ready,
  output logic                         opsum_snk_valid,
  output logic [DATA_WIDTH_PSUM-1:0]   opsum_snk_data,
  input  logic                         opsum_snk_ready
);

  typedef enum logic [1:0] {IDLE, CONFIG, STREAM, DONE} state_t;

  localparam int PW = CNT_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t state, state_next;

  logic [S_WIDTH-1:0] s_reg;
  logic [F_WIDTH-1:0] f_reg;
  logic [U_WIDTH-1:0] u_reg;
  logic [n_WIDTH-1:0] n_reg;
  logic [p_WIDTH-1:0] p_reg;
  logic [q_WIDTH-1:0] q_reg;
  logic [W_WIDTH-1:0] w_reg;

  logic [CNT_WIDTH-1:0] if_cnt, fi_cnt, ps_cnt, op_cnt;
  logic [CNT_WIDTH-1:0] n_if, n_fi, n_ps;
  logic [PW-1:0]        prod_fi, prod_ps;
  logic                 stream_en, all_complete;

  // Totals are pure functions of the latched shape, so they stay fixed for the whole layer.
  // The two extra product bits keep the >>2 exact before truncation to CNT_WIDTH.
  assign n_if    = CNT_WIDTH'(n_reg) * CNT_WIDTH'(w_reg) * CNT_WIDTH'(q_reg);
  assign prod_fi = PW'(p_reg) * PW'(q_reg) * PW'(s_reg);
  assign prod_ps = PW'(p_reg) * PW'(n_reg) * PW'(f_reg);
  assign n_fi    = CNT_WIDTH'(prod_fi >> 2);
  assign n_ps    = CNT_WIDTH'(prod_ps >> 2);

  assign all_complete = (if_cnt == n_if) && (fi_cnt == n_fi) &&
                        (ps_cnt == n_ps) && (op_cnt == n_ps);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_next   = state;
    busy         = 1'b0;
    done         = 1'b0;
    pe_configure = 1'b0;
    stream_en    = 1'b0;
    pe_S         = '0;
    pe_F         = '0;
    pe_U         = '0;
    pe_n         = '0;
    pe_p         = '0;
    pe_q         = '0;
    case (state)
      IDLE: if (start) state_next = CONFIG;
      CONFIG: begin
        busy         = 1'b1;
        pe_configure = 1'b1;
        pe_S         = s_reg;
        pe_F         = f_reg;
        pe_U         = u_reg;
        pe_n         = n_reg;
        pe_p         = p_reg;
        pe_q         = q_reg;
        state_next   = STREAM;
      end
      STREAM: begin
        busy      = 1'b1;
        stream_en = 1'b1;
        if (all_complete) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset is synchronous, but the outputs must already be quiet in the reset cycle itself.
    if (reset) begin
      busy         = 1'b0;
      done         = 1'b0;
      pe_configure = 1'b0;
      stream_en    = 1'b0;
      pe_S         = '0;
      pe_F         = '0;
      pe_U         = '0;
      pe_n         = '0;
      pe_p         = '0;
      pe_q         = '0;
    end
  end

  assign pe_enable = ~reset;

  assign push_ifmap      = stream_en & ifmap_src_valid & ~ifmap_fifo_full & (if_cnt < n_if);
  assign ifmap_src_ready = push_ifmap;
  assign ifmap           = push_ifmap ? ifmap_src_data : '0;

  assign push_filter      = stream_en & filter_src_valid & ~filter_fifo_full & (fi_cnt < n_fi);
  assign filter_src_ready = push_filter;
  assign filter           = push_filter ? filter_src_data : '0;

  assign push_ipsum      = stream_en & ipsum_src_valid & ~ipsum_fifo_full & (ps_cnt < n_ps);
  assign ipsum_src_ready = push_ipsum;
  assign ipsum           = push_ipsum ? ipsum_src_data : '0;

  // The opsum FIFO is first-word-fall-through, so its head is forwarded without a register.
  assign opsum_snk_valid = stream_en & ~opsum_fifo_empty & (op_cnt < n_ps);
  assign opsum_snk_data  = stream_en ? opsum : '0;
  assign pop_opsum       = opsum_snk_valid & opsum_snk_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      s_reg  <= '0;
      f_reg  <= '0;
      u_reg  <= '0;
      n_reg  <= '0;
      p_reg  <= '0;
      q_reg  <= '0;
      w_reg  <= '0;
      if_cnt <= '0;
      fi_cnt <= '0;
      ps_cnt <= '0;
      op_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        s_reg <= cfg_S;
        f_reg <= cfg_F;
        u_reg <= cfg_U;
        n_reg <= cfg_n;
        p_reg <= cfg_p;
        q_reg <= cfg_q;
        w_reg <= cfg_W;
      end
      if (state == DONE) begin
        if_cnt <= '0;
        fi_cnt <= '0;
        ps_cnt <= '0;
        op_cnt <= '0;
      end else begin
        if (push_ifmap)  if_cnt <= if_cnt + CNT_ONE;
        if (push_filter) fi_cnt <= fi_cnt + CNT_ONE;
        if (push_ipsum)  ps_cnt <= ps_cnt + CNT_ONE;
        if (pop_opsum)   op_cnt <= op_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_pe_stream_controller.sv
// Self-checking bench for pe_stream_controller: PE-side FIFOs, sources and the opsum sink
// are modelled with plain counters and queues; each layer is checked against its word quotas.
module tb_pe_stream_controller;

  localparam int DWI = 16;
  localparam int DWF = 64;
  localparam int DWP = 64;
  localparam int MAX_CYC = 20000;

  typedef struct {
    int S, F, U, n, p, q, W;
    int valid_pct;
    int ready_mode;   // 0 always ready, 1 ready on even cycles, 2 random
    int exp_if, exp_fi, exp_ps;
  } layer_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, start;
  logic [4:0]     cfg_S;
  logic [5:0]     cfg_F;
  logic [2:0]     cfg_U, cfg_n;
  logic [4:0]     cfg_p;
  logic [2:0]     cfg_q;
  logic [7:0]     cfg_W;
  logic           busy, done, pe_enable, pe_configure;
  logic [4:0]     pe_S;
  logic [5:0]     pe_F;
  logic [2:0]     pe_U, pe_n;
  logic [4:0]     pe_p;
  logic [2:0]     pe_q;
  logic           push_ifmap, ifmap_fifo_full;
  logic [DWI-1:0] ifmap;
  logic           push_filter, filter_fifo_full;
  logic [DWF-1:0] filter;
  logic           push_ipsum, ipsum_fifo_full;
  logic [DWP-1:0] ipsum;
  logic           pop_opsum, opsum_fifo_empty;
  logic [DWP-1:0] opsum;
  logic           ifmap_src_valid, ifmap_src_ready;
  logic [DWI-1:0] ifmap_src_data;
  logic           filter_src_valid, filter_src_ready;
  logic [DWF-1:0] filter_src_data;
  logic           ipsum_src_valid, ipsum_src_ready;
  logic [DWP-1:0] ipsum_src_data;
  logic           opsum_snk_valid, opsum_snk_ready;
  logic [DWP-1:0] opsum_snk_data;

  int n_tests = 0;
  int n_fail  = 0;
  layer_t tbl[5];

  pe_stream_controller dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_S(cfg_S), .cfg_F(cfg_F), .cfg_U(cfg_U), .cfg_n(cfg_n), .cfg_p(cfg_p),
    .cfg_q(cfg_q), .cfg_W(cfg_W),
    .busy(busy), .done(done), .pe_enable(pe_enable), .pe_configure(pe_configure),
    .pe_S(pe_S), .pe_F(pe_F), .pe_U(pe_U), .pe_n(pe_n), .pe_p(pe_p), .pe_q(pe_q),
    .push_ifmap(push_ifmap), .ifmap(ifmap), .ifmap_fifo_full(ifmap_fifo_full),
    .push_filter(push_filter), .filter(filter), .filter_fifo_full(filter_fifo_full),
    .push_ipsum(push_ipsum), .ipsum(ipsum), .ipsum_fifo_full(ipsum_fifo_full),
    .pop_opsum(pop_opsum), .opsum(opsum), .opsum_fifo_empty(opsum_fifo_empty),
    .ifmap_src_valid(ifmap_src_valid), .ifmap_src_data(ifmap_src_data),
    .ifmap_src_ready(ifmap_src_ready),
    .filter_src_valid(filter_src_valid), .filter_src_data(filter_src_data),
    .filter_src_ready(filter_src_ready),
    .ipsum_src_valid(ipsum_src_valid), .ipsum_src_data(ipsum_src_data),
    .ipsum_src_ready(ipsum_src_ready),
    .opsum_snk_valid(opsum_snk_valid), .opsum_snk_data(opsum_snk_data),
    .opsum_snk_ready(opsum_snk_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DWI-1:0] if_word(input int i);
    return DWI'(i * 37 + 32'h1234);
  endfunction
  function automatic logic [DWF-1:0] fi_word(input int i);
    return {32'(i) ^ 32'hA5A5_0000, 32'(i * 3 + 1)};
  endfunction
  function automatic logic [DWP-1:0] ps_word(input int i);
    return {32'hBEEF_0000 + 32'(i), ~32'(i)};
  endfunction
  function automatic logic [DWP-1:0] op_word(input int i);
    return {32'(i * 5), 32'hC0DE_0000 ^ 32'(i)};
  endfunction

  function automatic logic [7:0] handshakes();
    return {push_ifmap, push_filter, push_ipsum, pop_opsum,
            ifmap_src_ready, filter_src_ready, ipsum_src_ready, opsum_snk_valid};
  endfunction

  function automatic layer_t make_layer(input int S, F, U, n, p, q, W, vpct, rmode);
    layer_t l;
    l = '{S, F, U, n, p, q, W, vpct, rmode, 0, 0, 0};
    l.exp_if = (n * W * q) & 32'hFFFF;
    l.exp_fi = ((p * q * S) >> 2) & 32'hFFFF;
    l.exp_ps = ((p * n * F) >> 2) & 32'hFFFF;
    return l;
  endfunction

  // One complete layer. stall_at: cycle at which ifmap_fifo_full is forced for 20 cycles;
  // abort_at: pop count after which reset is asserted; mid_start_at: cycle with a stray start.
  task automatic run_layer(input layer_t L, input int stall_at, input int abort_at,
                           input int mid_start_at, input string tag);
    int n_if, n_fi, n_ps, n_op, c_if, c_fi, c_ps, produced;
    int viol, first_viol, done_cnt, done_cyc, last_evt, cyc, stall_base, stall_end;
    logic [DWP-1:0] opq[$];
    bit v_if, v_fi, v_ps, f_if, f_fi, f_ps, rdy, e_if, e_fi, e_ps, e_op, aborted, bad;
    bit x_if, x_fi, x_ps, x_op;
    n_if = 0; n_fi = 0; n_ps = 0; n_op = 0; c_if = 0; c_fi = 0; c_ps = 0; produced = 0;
    viol = 0; first_viol = -1; done_cnt = 0; done_cyc = -1; last_evt = 1; cyc = 1;
    stall_base = -1; stall_end = -1;
    e_if = 0; e_fi = 0; e_ps = 0; e_op = 0; aborted = 0;

    @(posedge clk); #1;
    start = 1'b1;
    cfg_S = 5'(L.S); cfg_F = 6'(L.F); cfg_U = 3'(L.U); cfg_n = 3'(L.n);
    cfg_p = 5'(L.p); cfg_q = 3'(L.q); cfg_W = 8'(L.W);
    ifmap_src_valid = 0; filter_src_valid = 0; ipsum_src_valid = 0;
    ifmap_fifo_full = 0; filter_fifo_full = 0; ipsum_fifo_full = 0;
    opsum_fifo_empty = 1; opsum_snk_ready = 0;
    @(negedge clk);
    check({tag, " busy in start cycle"}, busy, 0);
    check({tag, " pe_configure in start cycle"}, pe_configure, 0);

    @(posedge clk); #1;
    start = 1'b0;
    cfg_S = 5'($urandom); cfg_F = 6'($urandom); cfg_U = 3'($urandom); cfg_n = 3'($urandom);
    cfg_p = 5'($urandom); cfg_q = 3'($urandom); cfg_W = 8'($urandom);
    ifmap_src_valid = 1; filter_src_valid = 1; ipsum_src_valid = 1;
    opsum_fifo_empty = 0; opsum = op_word(99); opsum_snk_ready = 1;
    @(negedge clk);
    check({tag, " pe_configure in config"}, pe_configure, 1);
    check({tag, " busy in config"}, busy, 1);
    check({tag, " pe fields in config"}, {pe_S, pe_F, pe_U, pe_n, pe_p, pe_q},
          {5'(L.S), 6'(L.F), 3'(L.U), 3'(L.n), 5'(L.p), 3'(L.q)});
    check({tag, " handshakes in config"}, handshakes(), 0);

    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (e_if) begin n_if++; c_if++; end
      if (e_fi) begin n_fi++; c_fi++; end
      if (e_ps) begin n_ps++; c_ps++; end
      if (e_op) begin void'(opq.pop_front()); n_op++; end
      if (c_if > 0 && $urandom_range(99) < 60) c_if--;
      if (c_fi > 0 && $urandom_range(99) < 60) c_fi--;
      if (c_ps > 0 && $urandom_range(99) < 60) c_ps--;
      if (opq.size() < 8 && produced < L.exp_ps && $urandom_range(99) < 70) begin
        opq.push_back(op_word(produced));
        produced++;
      end
      v_if = $urandom_range(99) < L.valid_pct;
      v_fi = $urandom_range(99) < L.valid_pct;
      v_ps = $urandom_range(99) < L.valid_pct;
      f_if = (c_if >= 8) || (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 20);
      f_fi = c_fi >= 8;
      f_ps = c_ps >= 8;
      rdy  = (L.ready_mode == 0) ? 1'b1 :
             (L.ready_mode == 1) ? (cyc % 2 == 0) : ($urandom_range(1) == 1);
      if (cyc == stall_at) stall_base = n_if;
      if (cyc == stall_at + 20) stall_end = n_if;
      if (abort_at >= 0 && n_op == abort_at) begin
        aborted = 1; v_if = 1; v_fi = 1; v_ps = 1; rdy = 1;
        f_if = 0; f_fi = 0; f_ps = 0;
      end
      reset = aborted;
      start = (cyc == mid_start_at);
      if (cyc == mid_start_at) begin
        cfg_S = 5'd31; cfg_F = 6'd63; cfg_n = 3'd7; cfg_p = 5'd31; cfg_q = 3'd7; cfg_W = 8'd255;
      end
      ifmap_src_valid = v_if;  ifmap_src_data  = if_word(n_if);
      filter_src_valid = v_fi; filter_src_data = fi_word(n_fi);
      ipsum_src_valid = v_ps;  ipsum_src_data  = ps_word(n_ps);
      ifmap_fifo_full = f_if; filter_fifo_full = f_fi; ipsum_fifo_full = f_ps;
      opsum_fifo_empty = aborted ? 1'b0 : (opq.size() == 0);
      opsum = (opq.size() > 0) ? opq[0] : op_word(77);
      opsum_snk_ready = rdy;
      @(negedge clk);

      if (aborted) begin
        check({tag, " pops before abort"}, n_op, abort_at);
        check({tag, " handshakes in reset cycle"}, handshakes(), 0);
        check({tag, " busy/done/cfg/enable in reset cycle"},
              {busy, done, pe_configure, pe_enable}, 0);
        check({tag, " data outputs in reset cycle"},
              {ifmap, filter, ipsum, opsum_snk_data}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check({tag, " busy after abort"}, busy, 0);
        check({tag, " handshakes after abort"}, handshakes(), 0);
        check({tag, " pe_enable after abort"}, pe_enable, 1);
        return;
      end

      x_if = v_if && !f_if && (n_if < L.exp_if);
      x_fi = v_fi && !f_fi && (n_fi < L.exp_fi);
      x_ps = v_ps && !f_ps && (n_ps < L.exp_ps);
      x_op = (opq.size() > 0) && (n_op < L.exp_ps);
      bad = 0;
      bad |= (push_ifmap !== x_if) || (ifmap_src_ready !== x_if) ||
             (ifmap !== (x_if ? if_word(n_if) : DWI'(0)));
      bad |= (push_filter !== x_fi) || (filter_src_ready !== x_fi) ||
             (filter !== (x_fi ? fi_word(n_fi) : DWF'(0)));
      bad |= (push_ipsum !== x_ps) || (ipsum_src_ready !== x_ps) ||
             (ipsum !== (x_ps ? ps_word(n_ps) : DWP'(0)));
      bad |= (opsum_snk_valid !== x_op) || (pop_opsum !== (x_op && rdy));
      bad |= x_op && (opsum_snk_data !== op_word(n_op));
      bad |= (pe_configure !== 1'b0) || ({pe_S, pe_F, pe_U, pe_n, pe_p, pe_q} !== 25'd0);
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        check({tag, " busy after done"}, busy, 0);
        check({tag, " done is one cycle"}, done, 0);
      end else begin
        bad |= (busy !== 1'b1);
      end
      if (bad) begin
        viol++;
        if (first_viol < 0) first_viol = cyc;
      end
      e_if = push_ifmap; e_fi = push_filter; e_ps = push_ipsum; e_op = pop_opsum;
      if (e_if || e_fi || e_ps || e_op) last_evt = cyc;
      if (done_cyc >= 0 && cyc == done_cyc + 1) break;
      if (cyc > MAX_CYC) break;
    end

    check({tag, " finished within budget"}, cyc <= MAX_CYC, 1);
    check({tag, " ifmap pushes"}, n_if + e_if, L.exp_if);
    check({tag, " filter pushes"}, n_fi + e_fi, L.exp_fi);
    check({tag, " ipsum pushes"}, n_ps + e_ps, L.exp_ps);
    check({tag, " opsum pops"}, n_op + e_op, L.exp_ps);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " done two cycles after last transfer"}, done_cyc, last_evt + 2);
    check($sformatf("%s per-cycle protocol (first bad cycle %0d)", tag, first_viol), viol, 0);
    if (stall_at >= 0)
      check({tag, " ifmap pushes during stall"}, stall_end - stall_base, 0);
  endtask

  initial begin
    layer_t l;
    reset = 1; start = 0;
    cfg_S = 0; cfg_F = 0; cfg_U = 0; cfg_n = 0; cfg_p = 0; cfg_q = 0; cfg_W = 0;
    ifmap_src_valid = 1; filter_src_valid = 1; ipsum_src_valid = 1;
    ifmap_src_data = '1; filter_src_data = '1; ipsum_src_data = '1;
    ifmap_fifo_full = 0; filter_fifo_full = 0; ipsum_fifo_full = 0;
    opsum_fifo_empty = 0; opsum = '1; opsum_snk_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy/done/cfg/enable", {busy, done, pe_configure, pe_enable}, 0);
    check("reset handshakes", handshakes(), 0);
    check("reset data outputs", {ifmap, filter, ipsum, opsum_snk_data}, 0);
    check("reset pe fields", {pe_S, pe_F, pe_U, pe_n, pe_p, pe_q}, 0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    check("idle pe_enable", pe_enable, 1);
    check("idle busy", busy, 0);
    check("idle handshakes", handshakes(), 0);

    // {S, F, U, n, p, q, W, valid%, ready mode, N_IF, N_FI, N_PS}
    tbl[0] = '{3, 13, 1, 4, 16, 3, 15, 100, 0, 180, 36, 208};
    tbl[1] = '{5,  7, 2, 0,  0, 2,  9, 100, 0,   0,  0,   0};
    tbl[2] = '{0,  3, 1, 2,  4, 1,  5,  80, 2,  10,  0,   6};
    tbl[3] = '{3,  5, 4, 1,  3, 1,  7,  90, 0,   7,  2,   3};
    tbl[4] = '{5,  6, 2, 2,  8, 2, 10,  70, 2,  40, 20,  24};
    for (int i = 0; i < 5; i++)
      run_layer(tbl[i], -1, -1, -1, $sformatf("vec%0d", i));

    run_layer(tbl[0], 30, -1, -1, "ifmap_stall");
    l = tbl[0];
    l.ready_mode = 1;
    run_layer(l, -1, -1, -1, "toggle_ready");
    run_layer(tbl[0], -1, 50, -1, "abort");
    run_layer(tbl[0], -1, -1, -1, "rerun_after_abort");
    run_layer(tbl[0], -1, -1, 20, "start_while_busy");

    for (int r = 0; r < 4; r++) begin
      l = make_layer($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 7),
                     $urandom_range(0, 4), $urandom_range(0, 12), $urandom_range(0, 4),
                     $urandom_range(0, 12), $urandom_range(50, 100), 2);
      run_layer(l, -1, -1, -1, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
